// File: rtl/fnd_display_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_display_ctrl
//
// Converts a 14-bit binary count (nominal 0..9999) into four BCD digits with an
// iterative double-dabble FSM. The committed digits are shown on a common-anode
// 4-digit 7-segment display by time-multiplexed digit scanning.
//
// Parameters
//   SCAN_DIV : i_clk cycles per digit slot (>= 2)
//   BLANK_LZ : 1 = blank leading zeros on thousands/hundreds/tens digits
//
// Ports
//   i_clk      : system clock, rising edge
//   i_reset    : asynchronous, active-high reset
//   i_value    : binary value to display
//   o_bcd      : committed BCD {thousands, hundreds, tens, ones}
//   o_busy     : high while a conversion is in progress
//   o_overflow : last committed conversion saw i_value > 9999
//   o_fnd_com  : digit enables, active-low (bit0 = ones .. bit3 = thousands)
//   o_fnd_font : segments {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module fnd_display_ctrl #(
  parameter int SCAN_DIV = 100_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  output logic [15:0] o_bcd,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font
);

  localparam int              DIV_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [13:0]     MAX_VAL    = 14'd9999;
  localparam logic [3:0]      LAST_SHIFT = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Double-dabble correction for one nibble: add 3 when the digit is >= 5.
  function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Apply the correction to all four BCD nibbles.
  function automatic logic [15:0] add3_all(input logic [15:0] bcd);
    return {add3_nibble(bcd[15:12]), add3_nibble(bcd[11:8]),
            add3_nibble(bcd[7:4]),   add3_nibble(bcd[3:0])};
  endfunction

  // Active-low segment pattern for a BCD digit; dp always off.
  function automatic logic [7:0] font_of(input logic [3:0] dig);
    logic [7:0] f;
    case (dig)
      4'd0:    f = 8'hC0;
      4'd1:    f = 8'hF9;
      4'd2:    f = 8'hA4;
      4'd3:    f = 8'hB0;
      4'd4:    f = 8'h99;
      4'd5:    f = 8'h92;
      4'd6:    f = 8'h82;
      4'd7:    f = 8'hF8;
      4'd8:    f = 8'h80;
      4'd9:    f = 8'h90;
      default: f = 8'hFF;  // non-BCD nibble shows nothing
    endcase
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Converter state
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [13:0] r_last;
  logic [13:0] r_bin;
  logic [15:0] r_bcd_sh;
  logic [3:0]  r_cnt;
  logic        r_ovf_pend;
  logic [15:0] w_bcd_adj;

  assign w_bcd_adj = add3_all(r_bcd_sh);

  // Double-dabble converter FSM with registered o_bcd/o_overflow/o_busy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_last     <= 14'd0;
      r_bin      <= 14'd0;
      r_bcd_sh   <= 16'd0;
      r_cnt      <= 4'd0;
      r_ovf_pend <= 1'b0;
      o_bcd      <= 16'd0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_value != r_last) begin
            r_last   <= i_value;
            r_bcd_sh <= 16'd0;
            r_cnt    <= 4'd0;
            // Out-of-range values saturate to 9999 and raise overflow at commit.
            if (i_value > MAX_VAL) begin
              r_bin      <= MAX_VAL;
              r_ovf_pend <= 1'b1;
            end else begin
              r_bin      <= i_value;
              r_ovf_pend <= 1'b0;
            end
            r_state <= ST_SHIFT;
            o_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // Correct then shift {bcd, bin} left by one.
          r_bcd_sh <= {w_bcd_adj[14:0], r_bin[13]};
          r_bin    <= {r_bin[12:0], 1'b0};
          r_cnt    <= r_cnt + 4'd1;
          if (r_cnt == LAST_SHIFT) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          o_bcd      <= r_bcd_sh;
          o_overflow <= r_ovf_pend;
          o_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scanning
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;

  // Slot divider and digit index advance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  logic [3:0] w_digit;
  logic [3:0] w_com;
  logic       w_hi_zero;
  logic [7:0] w_font;

  // Select the current digit, its enable pattern, and its leading-zero status.
  always_comb begin
    w_digit   = 4'd0;
    w_com     = 4'b1111;
    w_hi_zero = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = o_bcd[3:0];
        w_com   = 4'b1110;
      end
      2'd1: begin
        w_digit   = o_bcd[7:4];
        w_com     = 4'b1101;
        w_hi_zero = (o_bcd[15:4] == 12'd0);
      end
      2'd2: begin
        w_digit   = o_bcd[11:8];
        w_com     = 4'b1011;
        w_hi_zero = (o_bcd[15:8] == 8'd0);
      end
      2'd3: begin
        w_digit   = o_bcd[15:12];
        w_com     = 4'b0111;
        w_hi_zero = (o_bcd[15:12] == 4'd0);
      end
      default: begin
        w_digit   = 4'd0;
        w_com     = 4'b1111;
        w_hi_zero = 1'b0;
      end
    endcase
    // Ones digit never sets w_hi_zero, so it is never blanked.
    if (BLANK_LZ && w_hi_zero) begin
      w_font = 8'hFF;
    end else begin
      w_font = font_of(w_digit);
    end
  end

  // Register the display pins so they never glitch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fnd_com  <= 4'b1110;
      o_fnd_font <= 8'hC0;
    end else begin
      o_fnd_com  <= w_com;
      o_fnd_font <= w_font;
    end
  end

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnd_display_ctrl
//
// Directed bench for fnd_display_ctrl. Two instances share clock, reset and
// value: u_dut_lz blanks leading zeros, u_dut_nz shows all digits. SCAN_DIV = 4.
// -----------------------------------------------------------------------------
module tb_fnd_display_ctrl;

  logic        i_clk;
  logic        i_reset;
  logic [13:0] i_value;

  logic [15:0] lz_bcd,  nz_bcd;
  logic        lz_busy, nz_busy;
  logic        lz_ovf,  nz_ovf;
  logic [3:0]  lz_com,  nz_com;
  logic [7:0]  lz_font, nz_font;

  int n_cmp = 0;
  int n_err = 0;

  fnd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut_lz (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_value    (i_value),
    .o_bcd      (lz_bcd),
    .o_busy     (lz_busy),
    .o_overflow (lz_ovf),
    .o_fnd_com  (lz_com),
    .o_fnd_font (lz_font)
  );

  fnd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_dut_nz (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_value    (i_value),
    .o_bcd      (nz_bcd),
    .o_busy     (nz_busy),
    .o_overflow (nz_ovf),
    .o_fnd_com  (nz_com),
    .o_fnd_font (nz_font)
  );

  // Free-running clock, period 10.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Start a conversion from IDLE and check the 16-edge timing and result.
  task automatic run_conv(input logic [13:0] val, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input logic [15:0] prev_bcd);
    int busy_cnt;
    busy_cnt = 0;
    i_value  = val;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      if (lz_busy) busy_cnt++;
      if (e == 15) check_val("bcd_hold_e15", lz_bcd, prev_bcd);
    end
    check_val("busy_cycles", busy_cnt, 15);
    check_val("busy_low_e16", lz_busy, 1'b0);
    check_val("bcd_e16", lz_bcd, exp_bcd);
    check_val("ovf_e16", lz_ovf, exp_ovf);
  endtask

  // Wait for the scan to enter the ones slot; bounded.
  task automatic align_to_slot0();
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      prev = lz_com;
      step(1);
      if (lz_com == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    check_val("scan_align", found, 1'b1);
  endtask

  // Check one full frame on both instances against expected per-slot fonts.
  task automatic check_frame(input logic [31:0] lz_fonts, input logic [31:0] nz_fonts);
    logic [3:0] exp_com;
    for (int s = 0; s < 4; s++) begin
      exp_com = 4'b1111;
      exp_com[s] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        check_val("lz_com", lz_com, exp_com);
        check_val("lz_font", lz_font, lz_fonts[8*s +: 8]);
        check_val("nz_com", nz_com, exp_com);
        check_val("nz_font", nz_font, nz_fonts[8*s +: 8]);
        step(1);
      end
    end
    check_val("com_wrap", lz_com, 4'b1110);
  endtask

  initial begin
    int busy_seen;

    // Reset values, visible before any clock edge.
    i_reset = 1'b1;
    i_value = 14'd0;
    #2;
    check_val("rst_bcd", lz_bcd, 16'h0000);
    check_val("rst_busy", lz_busy, 1'b0);
    check_val("rst_ovf", lz_ovf, 1'b0);
    check_val("rst_com", lz_com, 4'b1110);
    check_val("rst_font", lz_font, 8'hC0);
    step(2);
    i_reset = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (lz_busy) busy_seen++;
    end
    check_val("zero_no_conv", busy_seen, 0);

    // Normal conversions.
    run_conv(14'd1234, 16'h1234, 1'b0, 16'h0000);
    run_conv(14'd9999, 16'h9999, 1'b0, 16'h1234);
    run_conv(14'd5,    16'h0005, 1'b0, 16'h9999);
    run_conv(14'd1000, 16'h1000, 1'b0, 16'h0005);

    // Overflow saturates, then clears on a legal value.
    run_conv(14'd12000, 16'h9999, 1'b1, 16'h1000);
    run_conv(14'd42,    16'h0042, 1'b0, 16'h9999);
    check_val("nz_bcd_42", nz_bcd, 16'h0042);

    // Mid-conversion change: 200 arrives for edge 5 and is picked up afterwards.
    i_value = 14'd100;
    step(4);
    i_value = 14'd200;
    step(11);
    check_val("mid_e15_bcd", lz_bcd, 16'h0042);
    step(1);
    check_val("mid_e16_bcd", lz_bcd, 16'h0100);
    check_val("mid_e16_busy", lz_busy, 1'b0);
    step(1);
    check_val("mid_e17_busy", lz_busy, 1'b1);
    step(14);
    check_val("mid_e31_bcd", lz_bcd, 16'h0100);
    step(1);
    check_val("mid_e32_bcd", lz_bcd, 16'h0200);

    // Asynchronous reset in the middle of a conversion.
    i_value = 14'd555;
    step(5);
    check_val("pre_rst_busy", lz_busy, 1'b1);
    i_reset = 1'b1;
    #1;
    check_val("arst_bcd", lz_bcd, 16'h0000);
    check_val("arst_busy", lz_busy, 1'b0);
    check_val("arst_com", lz_com, 4'b1110);
    check_val("arst_font", lz_font, 8'hC0);
    i_value = 14'd0;
    step(2);
    i_reset = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (lz_busy) busy_seen++;
    end
    check_val("arst_no_conv", busy_seen, 0);

    // Scan with 0x0007: blanked vs unblanked. Fonts packed {thou,hund,tens,ones}.
    run_conv(14'd7, 16'h0007, 1'b0, 16'h0000);
    step(16);
    align_to_slot0();
    check_frame({8'hFF, 8'hFF, 8'hFF, 8'hF8}, {8'hC0, 8'hC0, 8'hC0, 8'hF8});

    // Internal zeros are never blanked.
    run_conv(14'd1005, 16'h1005, 1'b0, 16'h0007);
    step(16);
    align_to_slot0();
    check_frame({8'hF9, 8'hC0, 8'hC0, 8'h92}, {8'hF9, 8'hC0, 8'hC0, 8'h92});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fnd_display_ctrl.md
# fnd_display_ctrl

Consumer end of the 0–9999 up-counter value bus. Takes a 14-bit binary count and converts it to four BCD digits with an iterative double-dabble FSM. It then drives a common-anode 4-digit 7-segment (FND) display by time-multiplexed digit scanning. It sits between the counter and the board FND pins.

## Interface
- SCAN_DIV, 100_000, i_clk cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- BLANK_LZ, 1, 1 = blank leading zeros on the thousands, hundreds and tens digits; 0 = show all four digits.
- i_clk  input  1  system clock, rising-edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_value  input  14  binary value to display; nominal 0–9999.
- o_bcd  output  16  committed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- o_busy  output  1  high while a conversion is in progress.
- o_overflow  output  1  high when the last committed conversion saw i_value > 9999.
- o_fnd_com  output  4  digit enables, active-low; bit0 = ones … bit3 = thousands.
- o_fnd_font  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- The converter FSM has three states: IDLE, SHIFT and COMMIT.
- **IDLE**
  - If i_value ≠ r_last: latch the value into the shift register and set r_last ← i_value.
  - Any value > 9999 is latched as 9999, and the overflow is remembered.
  - Clear the iteration count and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT** (exactly 14 cycles)
  - Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - After the 14th shift, go to COMMIT.
- **COMMIT**
  - Update o_bcd and o_overflow together in the same cycle, then go to IDLE.
  - o_bcd never shows a partial result.
- i_value changes during SHIFT/COMMIT are ignored for that conversion.
- Back in IDLE, the next-cycle compare picks up any later change, so the display always converges to the final i_value.
- **Scan**
  - r_div counts 0..SCAN_DIV-1. At the terminal count, the digit index advances 0→1→2→3→0.
  - o_fnd_com has a single 0 at the bit for the current index.
- **Font encoding** (0–9): C0, F9, A4, B0, 99, 92, 82, F8, 80, 90. dp is always off (bit7 = 1).
- **Blanking:** with BLANK_LZ = 1, a digit at index k ≥ 1 outputs font FF when it and every higher digit are 0. The ones digit is never blanked.
- Nibble values > 9 cannot occur. If one does, the font is FF.
- **Reset values**
  - FSM = IDLE; r_last = 0; o_bcd = 0x0000; o_busy = 0; o_overflow = 0.
  - r_div = 0; index = 0.
  - o_fnd_com = 4'b1110; o_fnd_font = 8'hC0.
  - Because r_last = 0, i_value = 0 after reset starts no conversion.
- **Reset mid-operation:** asserting i_reset aborts any conversion. All registers return to their reset values immediately (asynchronous). The conversion restarts after release if i_value ≠ 0.

## Timing
- Edge 1 is the first rising edge on which i_value ≠ r_last, seen in IDLE. This edge loads the value.
- Edges 2–15 perform the 14 shifts.
- Edge 16 commits o_bcd and o_overflow.
- o_busy = (state ≠ IDLE). It is high for exactly 15 cycles: from after edge 1 until after edge 16.
- Minimum spacing between commits is 16 cycles.
- o_fnd_com and o_fnd_font are registered:
  - they reflect an index change or an o_bcd change one edge later;
  - they never glitch combinationally.
- Each digit is enabled for exactly SCAN_DIV cycles. A full frame is 4·SCAN_DIV cycles.
- A commit in the middle of a slot updates the font on the next edge. It does not disturb the scan timing.

## Test plan
- **Reset:** assert i_reset mid-run → o_bcd = 0000, o_busy = 0, o_fnd_com = 1110, o_fnd_font = C0 with no clock edge. Release with i_value = 0 → o_busy stays 0.
- **Conversion:** i_value 0 → 1234 → o_busy high for 15 cycles; o_bcd = 0x1234 exactly on edge 16; o_overflow = 0. Repeat for 9999 → 0x9999, 5 → 0x0005, 1000 → 0x1000.
- **Overflow:** i_value = 12000 → o_bcd = 0x9999, o_overflow = 1. Then i_value = 42 → o_bcd = 0x0042, o_overflow = 0.
- **Mid-conversion change:** i_value = 100, then 200 on edge 5 → commit 0x0100 at edge 16, then a new conversion commits 0x0200 at edge 32.
- **Scan (SCAN_DIV = 4, BLANK_LZ = 1, o_bcd = 0x0007):**
  - o_fnd_com steps 1110 → 1101 → 1011 → 0111 → 1110, changing every 4 cycles;
  - fonts are F8, FF, FF, FF.
  - With BLANK_LZ = 0, fonts are F8, C0, C0, C0.
- **Internal zero (o_bcd = 0x1005, BLANK_LZ = 1):** fonts are 92, C0, C0, F9 for ones, tens, hundreds, thousands. Internal zeros are not blanked.
